// File: rtl/bg_scroll_ctrl.sv
// Background scroll controller: ramped near-layer scrolling with wall/edge stops.
// Define BG_PARALLAX_EN to drive far_pos with a shifted (parallax) copy of scroll_pos.
module bg_scroll_ctrl #(
    parameter int POS_W          = 10,
    parameter int WORLD_W        = 555,
    parameter int VIEW_W         = 150,
    parameter int MAX_SPEED      = 4,
    parameter int ACCEL_FRAMES   = 4,
    parameter int PARALLAX_SHIFT = 1
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             dead_reset,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             can_left,
    input  logic             can_right,
    input  logic             freeze,
    output logic [POS_W-1:0] scroll_pos,
    output logic [3:0]       scroll_vel,
    output logic             at_left,
    output logic             at_right,
    output logic             moving,
    output logic [POS_W-1:0] far_pos
);

    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [POS_W-1:0] MAX_POS  = POS_W'(WORLD_W - VIEW_W - 1);
    localparam logic [2:0]       MAX_SPD  = 3'(MAX_SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    state_t           state, state_nx;
    logic [2:0]       spd, spd_nx;
    logic             dir, dir_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [POS_W-1:0] pos, pos_nx;

    logic             req_r, req_l, same_req, permit, hit_right, hit_left;
    logic [POS_W:0]   pos_plus;
    logic [POS_W-1:0] pos_minus;

    // dir=1 is rightward; simultaneous left and right requests cancel out
    assign req_r     = right_req & ~left_req;
    assign req_l     = left_req & ~right_req;
    assign same_req  = dir ? req_r : req_l;
    assign permit    = dir ? can_right : can_left;
    assign pos_plus  = {1'b0, pos} + (POS_W+1)'(spd);
    assign pos_minus = pos - POS_W'(spd);
    assign hit_right = pos_plus >= {1'b0, MAX_POS};
    assign hit_left  = pos <= POS_W'(spd);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            spd   <= '0;
            dir   <= 1'b1;
            cnt   <= '0;
            pos   <= '0;
        end else if (dead_reset) begin
            state <= IDLE;
            spd   <= '0;
            dir   <= 1'b1;
            cnt   <= '0;
            pos   <= '0;
        end else if (!freeze) begin
            state <= state_nx;
            spd   <= spd_nx;
            dir   <= dir_nx;
            cnt   <= cnt_nx;
            pos   <= pos_nx;
        end
    end

    always_comb begin
        state_nx = state;
        spd_nx   = spd;
        dir_nx   = dir;
        cnt_nx   = cnt;
        pos_nx   = pos;
        case (state)
            IDLE: begin
                if (req_r && can_right && (pos < MAX_POS)) begin
                    state_nx = ACCEL;
                    dir_nx   = 1'b1;
                    spd_nx   = 3'd1;
                    cnt_nx   = '0;
                end else if (req_l && can_left && (pos != '0)) begin
                    state_nx = ACCEL;
                    dir_nx   = 1'b0;
                    spd_nx   = 3'd1;
                    cnt_nx   = '0;
                end
            end
            default: begin
                // Wall and world-edge stops take effect before any speed change
                if (!permit) begin
                    state_nx = IDLE;
                    spd_nx   = '0;
                    cnt_nx   = '0;
                end else if (dir && hit_right) begin
                    state_nx = IDLE;
                    spd_nx   = '0;
                    cnt_nx   = '0;
                    pos_nx   = MAX_POS;
                end else if (!dir && hit_left) begin
                    state_nx = IDLE;
                    spd_nx   = '0;
                    cnt_nx   = '0;
                    pos_nx   = '0;
                end else begin
                    pos_nx = dir ? pos_plus[POS_W-1:0] : pos_minus;
                    case (state)
                        ACCEL: begin
                            if (!same_req) begin
                                state_nx = DECEL;
                                cnt_nx   = '0;
                            end else if (spd >= MAX_SPD) begin
                                state_nx = CRUISE;
                            end else if (cnt == CNT_LAST) begin
                                spd_nx = spd + 3'd1;
                                cnt_nx = '0;
                                if (spd + 3'd1 == MAX_SPD)
                                    state_nx = CRUISE;
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                        CRUISE: begin
                            if (!same_req) begin
                                state_nx = DECEL;
                                cnt_nx   = '0;
                            end
                        end
                        DECEL: begin
                            if (same_req) begin
                                state_nx = ACCEL;
                                cnt_nx   = '0;
                            end else if (cnt == CNT_LAST) begin
                                spd_nx = spd - 3'd1;
                                cnt_nx = '0;
                                if (spd == 3'd1)
                                    state_nx = IDLE;
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign scroll_pos = pos;
    assign scroll_vel = dir ? {1'b0, spd} : -{1'b0, spd};
    assign at_left    = (pos == '0);
    assign at_right   = (pos == MAX_POS);
    assign moving     = (spd != '0);

`ifdef BG_PARALLAX_EN
    assign far_pos = pos >> PARALLAX_SHIFT;
`else
    // Constant-folds to zero; no far-layer shifter is built
    assign far_pos = {POS_W{1'b0}} >> PARALLAX_SHIFT;
`endif

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Self-checking bench for bg_scroll_ctrl: directed scenarios plus randomized
// frames compared against a frame-level behavioural model of the scroller.
module tb_bg_scroll_ctrl;

    localparam int POS_W          = 10;
    localparam int MAX_POS        = 404;
    localparam int MAX_SPEED      = 4;
    localparam int ACCEL_FRAMES   = 4;
    localparam int PARALLAX_SHIFT = 1;

    logic             frame_clk = 1'b0;
    logic             Reset, dead_reset, left_req, right_req, can_left, can_right, freeze;
    logic [POS_W-1:0] scroll_pos, far_pos;
    logic [3:0]       scroll_vel;
    logic             at_left, at_right, moving;

    int check_count = 0;
    int error_count = 0;

    // Model: position, speed magnitude, direction (+1/-1), motion phase and
    // frames spent in the current speed step. Phase 1 speeding up, 2 cruising, 3 slowing.
    int m_pos, m_spd, m_dir, m_mode, m_frames;

    bg_scroll_ctrl #(
        .POS_W(POS_W), .WORLD_W(555), .VIEW_W(150), .MAX_SPEED(MAX_SPEED),
        .ACCEL_FRAMES(ACCEL_FRAMES), .PARALLAX_SHIFT(PARALLAX_SHIFT)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .dead_reset(dead_reset),
        .left_req(left_req), .right_req(right_req),
        .can_left(can_left), .can_right(can_right), .freeze(freeze),
        .scroll_pos(scroll_pos), .scroll_vel(scroll_vel),
        .at_left(at_left), .at_right(at_right), .moving(moving),
        .far_pos(far_pos)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic void model_clear();
        m_pos = 0; m_spd = 0; m_dir = 1; m_mode = 0; m_frames = 0;
    endfunction

    function automatic void model_step(bit l, bit r, bit cl, bit cr, bit fr, bit dead);
        int req;
        int nxt;
        bit permit;
        if (dead) begin
            model_clear();
            return;
        end
        if (fr) return;
        req = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        if (m_spd == 0) begin
            if (req == 1 && cr && m_pos < MAX_POS) begin
                m_dir = 1; m_spd = 1; m_mode = 1; m_frames = 0;
            end else if (req == -1 && cl && m_pos > 0) begin
                m_dir = -1; m_spd = 1; m_mode = 1; m_frames = 0;
            end
            return;
        end
        permit = (m_dir > 0) ? cr : cl;
        if (!permit) begin
            m_spd = 0;
            return;
        end
        nxt = m_pos + m_dir * m_spd;
        if (m_dir > 0 && nxt >= MAX_POS) begin
            m_pos = MAX_POS; m_spd = 0;
            return;
        end
        if (m_dir < 0 && nxt <= 0) begin
            m_pos = 0; m_spd = 0;
            return;
        end
        m_pos = nxt;
        if (m_mode == 1) begin
            if (req != m_dir) begin
                m_mode = 3; m_frames = 0;
            end else if (m_spd >= MAX_SPEED) begin
                m_mode = 2;
            end else if (m_frames == ACCEL_FRAMES - 1) begin
                m_spd++; m_frames = 0;
                if (m_spd == MAX_SPEED) m_mode = 2;
            end else begin
                m_frames++;
            end
        end else if (m_mode == 2) begin
            if (req != m_dir) begin
                m_mode = 3; m_frames = 0;
            end
        end else begin
            if (req == m_dir) begin
                m_mode = 1; m_frames = 0;
            end else if (m_frames == ACCEL_FRAMES - 1) begin
                m_spd--; m_frames = 0;
            end else begin
                m_frames++;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int vel_now();
        return int'($signed(scroll_vel));
    endfunction

    function automatic int far_expect(int p);
`ifdef BG_PARALLAX_EN
        return p >> PARALLAX_SHIFT;
`else
        return 0 * p;
`endif
    endfunction

    task automatic checkAll(input string where);
        checkOutput({where, ".pos"},      int'(scroll_pos), m_pos);
        checkOutput({where, ".vel"},      vel_now(),        m_dir * m_spd);
        checkOutput({where, ".at_left"},  int'(at_left),    int'(m_pos == 0));
        checkOutput({where, ".at_right"}, int'(at_right),   int'(m_pos == MAX_POS));
        checkOutput({where, ".moving"},   int'(moving),     int'(m_spd != 0));
        checkOutput({where, ".far_pos"},  int'(far_pos),    far_expect(m_pos));
    endtask

    // Drive one frame's inputs, advance the model, then check just after the edge
    task automatic applyStimulus(input bit l, input bit r, input bit cl, input bit cr,
                                 input bit fr, input bit dead);
        left_req = l; right_req = r; can_left = cl; can_right = cr;
        freeze = fr; dead_reset = dead;
        model_step(l, r, cl, cr, fr, dead);
        @(posedge frame_clk);
        #1;
        checkAll("frame");
    endtask

    task automatic pulseReset();
        #3;
        Reset = 1'b1;
        #1;
        model_clear();
        checkAll("async_reset");
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        int intent, len;
        bit l, r;
        Reset = 1'b1; dead_reset = 1'b0; left_req = 1'b0; right_req = 1'b0;
        can_left = 1'b1; can_right = 1'b1; freeze = 1'b0;
        #1;
        model_clear();
        checkAll("reset");
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;

        // Ramp up over 13 frames, then coast down in 4-frame steps
        repeat (13) applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("ramp_pos", int'(scroll_pos), 24);
        checkOutput("ramp_vel", vel_now(), 4);
`ifdef BG_PARALLAX_EN
        checkOutput("ramp_far", int'(far_pos), 12);
`else
        checkOutput("ramp_far", int'(far_pos), 0);
`endif
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 0);
            if ((i - 1) % 4 == 0) checkOutput("coast_vel", vel_now(), 4 - (i - 1) / 4);
        end
        checkOutput("coast_pos", int'(scroll_pos), 68);

        // Wall stop at speed 3, then conflicting requests stay idle
        pulseReset();
        repeat (9) applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("wall_pre_vel", vel_now(), 3);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("wall_vel", vel_now(), 0);
        checkOutput("wall_pos", int'(scroll_pos), 12);
        repeat (3) applyStimulus(1, 1, 1, 1, 0, 0);
        checkOutput("both_vel", vel_now(), 0);
        checkOutput("both_pos", int'(scroll_pos), 12);

        // Walk to pos 2, then cruise right into the 404 edge from 402
        pulseReset();
        repeat (3) applyStimulus(0, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("edge_start", int'(scroll_pos), 2);
        repeat (107) applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("edge_pre_pos", int'(scroll_pos), 402);
        checkOutput("edge_pre_vel", vel_now(), 4);
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("edge_pos", int'(scroll_pos), 404);
        checkOutput("edge_vel", vel_now(), 0);
        checkOutput("edge_at_right", int'(at_right), 1);
        repeat (3) applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("edge_hold_pos", int'(scroll_pos), 404);

        // Death clears state even while frozen
        pulseReset();
        repeat (32) applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("dead_pre_pos", int'(scroll_pos), 100);
        checkOutput("dead_pre_vel", vel_now(), 4);
        applyStimulus(0, 1, 1, 1, 1, 1);
        checkOutput("dead_pos", int'(scroll_pos), 0);
        checkOutput("dead_vel", vel_now(), 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("dead_after_pos", int'(scroll_pos), 0);

        // Randomized segments of held intent with occasional walls, pauses and resets
        for (int seg = 0; seg < 150; seg++) begin
            intent = $urandom_range(0, 9);
            len    = $urandom_range(5, 60);
            for (int j = 0; j < len; j++) begin
                if (intent <= 3)      begin l = 0; r = 1; end
                else if (intent <= 6) begin l = 1; r = 0; end
                else if (intent == 7) begin l = 0; r = 0; end
                else if (intent == 8) begin l = 1; r = 1; end
                else begin l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
                applyStimulus(l, r,
                              $urandom_range(0, 49) != 0, $urandom_range(0, 49) != 0,
                              $urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0);
                if ($urandom_range(0, 499) == 0) pulseReset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
